change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vm_pkg.sv | 23 ++
 rtl/denom_picker.sv | 25 ++
 rtl/change_dispenser.sv | 131 +++++++++++++
 tb/tb_change_dispenser.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: shared definitions for the change dispenser
//   NUM_DENOM  number of coin/note denominations held in inventory
//   TIMEOUT    cycles allowed in EJECT without an ejector acknowledge
//   state_t    FSM state codes (5..7 are illegal and recover to IDLE)
//   denom()    value of a denomination index, in units of 10 sen
package vm_pkg;
    localparam int NUM_DENOM = 6;
    localparam logic [7:0] TIMEOUT = 8'd255;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        EJECT  = 3'd2,
        DONE   = 3'd3,
        FAULT  = 3'd4
    } state_t;
    function automatic logic [9:0] denom(input logic [2:0] i);
        return i == 3'd0 ? 10'd100 :
               i == 3'd1 ? 10'd50  :
               i == 3'd2 ? 10'd20  :
               i == 3'd3 ? 10'd10  :
               i == 3'd4 ? 10'd5   : 10'd1;
    endfunction
endpackage

// File: rtl/denom_picker.sv
// denom_picker: combinational choice of the largest payable denomination in stock
//   rem    amount still to pay
//   inv    packed 8-bit inventory counters, index 0 in the low byte
//   found  some denomination fits rem and has stock
//   index  lowest such index (largest value)
module denom_picker
    import vm_pkg::*;
(
    input  logic [9:0]             rem,
    input  logic [NUM_DENOM*8-1:0] inv,
    output logic                   found,
    output logic [2:0]             index
);
    // scan from the smallest value upward so the largest fitting one wins
    always_comb begin
        found = 1'b0;
        index = 3'd0;
        for (int i = NUM_DENOM - 1; i >= 0; i--) begin
            if (denom(3'(i)) <= rem && inv[i*8 +: 8] != 8'd0) begin
                found = 1'b1;
                index = 3'(i);
            end
        end
    end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy change payout FSM driving a one-unit ejector
//   clk, rst            clock; asynchronous active-low reset
//   start, amount       payout request and amount (units of 10 sen), taken in IDLE
//   maintenance         enables refill, clears FAULT
//   refill, refill_sel, refill_cnt   saturating inventory load strobe
//   eject_ack           ejector has released one unit
//   eject_req, eject_sel            ejector request and denomination index
//   busy, done, shortfall, remainder, fault, state   status outputs
module change_dispenser
    import vm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] amount,
    input  logic       maintenance,
    input  logic       refill,
    input  logic [2:0] refill_sel,
    input  logic [7:0] refill_cnt,
    input  logic       eject_ack,
    output logic       eject_req,
    output logic [2:0] eject_sel,
    output logic       busy,
    output logic       done,
    output logic       shortfall,
    output logic [9:0] remainder,
    output logic       fault,
    output logic [2:0] state
);
    state_t                 st;
    logic [9:0]             rem;
    logic [7:0]             inv [NUM_DENOM];
    logic [7:0]             tmo;
    logic [NUM_DENOM*8-1:0] inv_vec;
    logic                   found;
    logic [2:0]             pick;
    logic                   sel_ok;
    logic [2:0]             sel_idx;
    logic [8:0]             sum;

    for (genvar g = 0; g < NUM_DENOM; g++) begin : g_pack
        assign inv_vec[g*8 +: 8] = inv[g];
    end

    assign state   = st;
    assign sel_ok  = refill_sel < 3'(NUM_DENOM);
    assign sel_idx = sel_ok ? refill_sel : 3'd0;
    assign sum     = {1'b0, inv[sel_idx]} + {1'b0, refill_cnt};

    denom_picker u_picker (
        .rem   (rem),
        .inv   (inv_vec),
        .found (found),
        .index (pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            rem       <= 10'd0;
            tmo       <= 8'd0;
            for (int i = 0; i < NUM_DENOM; i++) inv[i] <= 8'd0;
            eject_req <= 1'b0;
            eject_sel <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            shortfall <= 1'b0;
            remainder <= 10'd0;
            fault     <= 1'b0;
        end else begin
            done      <= 1'b0;
            shortfall <= 1'b0;
            case (st)
                IDLE: begin
                    if (start && !maintenance) begin
                        rem  <= amount;
                        st   <= SELECT;
                        busy <= 1'b1;
                    end else if (maintenance && refill && sel_ok) begin
                        inv[sel_idx] <= sum[8] ? 8'hff : sum[7:0];
                    end
                end
                SELECT: begin
                    if (found) begin
                        st        <= EJECT;
                        eject_req <= 1'b1;
                        eject_sel <= pick;
                        tmo       <= 8'd0;
                    end else begin
                        st        <= DONE;
                        done      <= 1'b1;
                        shortfall <= rem != 10'd0;
                        remainder <= rem;
                    end
                end
                EJECT: begin
                    // selection guarantees denom <= rem and inv > 0, so no underflow
                    if (eject_ack) begin
                        rem            <= rem - denom(eject_sel);
                        inv[eject_sel] <= inv[eject_sel] - 8'd1;
                        eject_req      <= 1'b0;
                        st             <= SELECT;
                    end else if (tmo == TIMEOUT - 8'd1) begin
                        eject_req <= 1'b0;
                        fault     <= 1'b1;
                        st        <= FAULT;
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end
                DONE: begin
                    st   <= IDLE;
                    busy <= 1'b0;
                end
                FAULT: begin
                    if (maintenance) begin
                        st    <= IDLE;
                        fault <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    st        <= IDLE;
                    busy      <= 1'b0;
                    eject_req <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench for change_dispenser
module tb_change_dispenser;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] amount = 10'd0;
    logic       maintenance = 1'b0;
    logic       refill = 1'b0;
    logic [2:0] refill_sel = 3'd0;
    logic [7:0] refill_cnt = 8'd0;
    logic       eject_ack = 1'b0;
    logic       eject_req, busy, done, shortfall, fault;
    logic [2:0] eject_sel, state;
    logic [9:0] remainder;
    int checks = 0;
    int errors = 0;
    int minv [6];
    int exp_q [$];
    int dv [6] = '{100, 50, 20, 10, 5, 1};

    change_dispenser dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .amount      (amount),
        .maintenance (maintenance),
        .refill      (refill),
        .refill_sel  (refill_sel),
        .refill_cnt  (refill_cnt),
        .eject_ack   (eject_ack),
        .eject_req   (eject_req),
        .eject_sel   (eject_sel),
        .busy        (busy),
        .done        (done),
        .shortfall   (shortfall),
        .remainder   (remainder),
        .fault       (fault),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_inv();
        for (int i = 0; i < 6; i++) chk($sformatf("inv%0d", i), 32'(dut.inv[i]), minv[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) minv[i] = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic fill(input int sel, input int cnt);
        maintenance = 1'b1;
        refill = 1'b1;
        refill_sel = 3'(sel);
        refill_cnt = 8'(cnt);
        @(negedge clk);
        refill = 1'b0;
        maintenance = 1'b0;
        if (sel < 6) minv[sel] = minv[sel] + cnt > 255 ? 255 : minv[sel] + cnt;
    endtask

    task automatic pay(input int amt);
        int r;
        int exp_rem;
        int idx;
        bit fin;
        r = amt;
        fin = 1'b0;
        for (int i = 0; i < 6; i++)
            while (dv[i] <= r && minv[i] > 0) begin
                exp_q.push_back(i);
                r -= dv[i];
                minv[i]--;
            end
        exp_rem = r;
        start = 1'b1;
        amount = 10'(amt);
        @(negedge clk);
        start = 1'b0;
        chk("select_state", 32'(state), 1);
        @(negedge clk);
        chk("latency", 32'(eject_req | done), 1);
        for (int n = 0; n < 3000 && !fin; n++) begin
            if (done) begin
                chk("queue_empty", exp_q.size(), 0);
                chk("remainder", 32'(remainder), exp_rem);
                chk("shortfall", 32'(shortfall), 32'(exp_rem != 0));
                fin = 1'b1;
            end else if (eject_req) begin
                idx = exp_q.size() > 0 ? exp_q.pop_front() : -1;
                chk("eject_sel", 32'(eject_sel), idx);
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    chk("sel_hold", 32'({eject_req, eject_sel}), 32'({1'b1, idx[2:0]}));
                end
                eject_ack = 1'b1;
                @(negedge clk);
                eject_ack = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        chk("pay_finished", 32'(fin), 1);
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("idle_after", 32'({state, busy}), 0);
        check_inv();
    endtask

    initial begin
        int n;
        #2 rst = 1'b0;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_outs", 32'({eject_req, eject_sel, busy, done, shortfall, fault}), 0);
        chk("rst_remainder", 32'(remainder), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_inv();

        for (int i = 0; i < 6; i++) fill(i, 10);
        pay(186);
        pay(0);

        do_reset();
        for (int i = 1; i < 6; i++) fill(i, 10);
        pay(100);

        do_reset();
        fill(5, 3);
        pay(7);

        do_reset();
        fill(2, 250);
        fill(2, 10);
        check_inv();
        fill(7, 50);
        check_inv();

        do_reset();
        fill(0, 10);
        start = 1'b1;
        amount = 10'd100;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!fault && n < 400) begin
            if (eject_req) n++;
            @(negedge clk);
        end
        chk("timeout_cycles", n, 255);
        chk("fault_state", 32'({state, fault, eject_req, busy}), 32'({3'd4, 1'b1, 1'b0, 1'b1}));
        check_inv();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("fault_hold", 32'(state), 4);
        maintenance = 1'b1;
        @(negedge clk);
        maintenance = 1'b0;
        chk("fault_clear", 32'({state, fault}), 0);

        do_reset();
        fill(3, 10);
        start = 1'b1;
        amount = 10'd50;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!eject_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("eject_seen", 32'(eject_req), 1);
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) minv[i] = 0;
        #1;
        chk("async_outs", 32'({eject_req, busy, done, fault, state}), 0);
        check_inv();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fill(1, 2);
        pay(50);

        do_reset();
        for (int i = 0; i < 6; i++) fill(i, $urandom_range(0, 6));
        for (int k = 0; k < 4; k++) pay($urandom_range(0, 1023));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
